// File: rtl/lc_mem_model.sv
`default_nettype none
// ============================================================================
// Module      : lc_mem_model
// Description : Last-level-cache responder. Serves line-sized reads and writes
//               from NUM_CH L1 clients over valid/ready handshakes with a fixed
//               access latency. Arbitration is round-robin. A backdoor preload
//               port writes whole lines at any time.
//               Optional feature macro: LC_MEM_ERR_EN (out-of-range detection
//               on err_out; without it addresses wrap and err_out is 0).
// Revision    : 1.0 - initial release
// ============================================================================
module lc_mem_model #(
    parameter int NUM_CH      = 2,
    parameter int LINE_BYTES  = 64,
    parameter int DEPTH_LINES = 64,
    parameter int LATENCY     = 4
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           load_valid_in,
    input  logic [63:0]                    load_addr_in,
    input  logic [LINE_BYTES*8-1:0]        load_value_in,
    input  logic [NUM_CH-1:0]              req_valid_in,
    output logic [NUM_CH-1:0]              req_ready_out,
    input  logic [NUM_CH-1:0]              req_we_in,
    input  logic [NUM_CH*64-1:0]           req_addr_in,
    input  logic [NUM_CH*LINE_BYTES*8-1:0] req_value_in,
    output logic [NUM_CH-1:0]              resp_valid_out,
    input  logic [NUM_CH-1:0]              resp_ready_in,
    output logic [63:0]                    resp_addr_out,
    output logic [LINE_BYTES*8-1:0]        resp_value_out,
    output logic                           busy_out,
    output logic                           err_out
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(DEPTH_LINES);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // WAIT lasts LATENCY-1 cycles; the counter runs LATENCY-2 down to 0.
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     r_resp_ch;
    logic [63:0]         r_resp_addr;
    logic [LINE_W-1:0]   r_resp_value;
    logic                r_resp_err;
    logic [LINE_W-1:0]   r_mem [DEPTH_LINES];

    logic                w_lo_any;
    logic [CH_W-1:0]     w_lo_idx;
    logic                w_hi_any;
    logic [CH_W-1:0]     w_hi_idx;
    logic [CH_W-1:0]     w_grant_idx;
    logic                w_accept;
    logic [63:0]         w_sel_addr;
    logic [LINE_W-1:0]   w_sel_data;
    logic                w_sel_we;
    logic [IDX_W-1:0]    w_sel_idx;
    logic [IDX_W-1:0]    w_load_idx;
    logic                w_req_oor;
    logic                w_load_oor;
    logic                w_unused;

    // Round-robin search: lowest valid index >= rr_ptr, else lowest valid overall.
    always_comb begin
        w_lo_any = 1'b0;
        w_lo_idx = '0;
        w_hi_any = 1'b0;
        w_hi_idx = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (req_valid_in[j]) begin
                w_lo_any = 1'b1;
                w_lo_idx = CH_W'(j);
            end
            if (req_valid_in[j] && (CH_W'(j) >= r_rr_ptr)) begin
                w_hi_any = 1'b1;
                w_hi_idx = CH_W'(j);
            end
        end
    end

    assign w_grant_idx   = w_hi_any ? w_hi_idx : w_lo_idx;
    assign w_accept      = (r_state == ST_IDLE) && !load_valid_in && w_lo_any && !rst_in;
    assign req_ready_out = w_accept ? (NUM_CH'(1) << w_grant_idx) : '0;

    assign w_sel_addr = req_addr_in[w_grant_idx * 64 +: 64];
    assign w_sel_data = req_value_in[w_grant_idx * LINE_W +: LINE_W];
    assign w_sel_we   = req_we_in[w_grant_idx];
    assign w_sel_idx  = w_sel_addr[OFF_W +: IDX_W];
    assign w_load_idx = load_addr_in[OFF_W +: IDX_W];

`ifdef LC_MEM_ERR_EN
    assign w_req_oor  = |(w_sel_addr >> (OFF_W + IDX_W));
    assign w_load_oor = |(load_addr_in >> (OFF_W + IDX_W));
`else
    assign w_req_oor  = 1'b0;
    assign w_load_oor = 1'b0;
`endif

    // Offset bits (and, without range checking, upper bits) are intentionally ignored.
    assign w_unused = ^{load_addr_in, w_sel_addr};

    // Backing store: preload and accepted writes never coincide since a preload blocks accepts.
    always_ff @(posedge clk_in) begin
        if (load_valid_in && !w_load_oor) begin
            r_mem[w_load_idx] <= load_value_in;
        end else if (w_accept && w_sel_we && !w_req_oor) begin
            r_mem[w_sel_idx] <= w_sel_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Response capture on accept, round-robin pointer and latency counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_resp_value <= '0;
            r_resp_addr  <= '0;
            r_resp_ch    <= '0;
            r_resp_err   <= 1'b0;
            r_rr_ptr     <= '0;
            r_cnt        <= '0;
        end else if (w_accept) begin
            r_resp_ch   <= w_grant_idx;
            r_resp_addr <= {w_sel_addr[63:OFF_W], {OFF_W{1'b0}}};
            r_resp_err  <= w_req_oor;
            r_cnt       <= C_CNT_INIT;
            r_rr_ptr    <= (w_grant_idx == CH_W'(NUM_CH - 1)) ? '0 : w_grant_idx + CH_W'(1);
            if (w_sel_we) begin
                r_resp_value <= w_sel_data;
            end else if (w_req_oor) begin
                r_resp_value <= '0;
            end else begin
                r_resp_value <= r_mem[w_sel_idx];
            end
        end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Next-state logic and state-derived outputs.
    always_comb begin
        w_state_nxt    = r_state;
        resp_valid_out = '0;
        busy_out       = (r_state != ST_IDLE);
        err_out        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid_out = NUM_CH'(1) << r_resp_ch;
                err_out        = r_resp_err;
                if (resp_ready_in[r_resp_ch]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign resp_addr_out  = r_resp_addr;
    assign resp_value_out = r_resp_value;

endmodule
`default_nettype wire

// File: tb/tb_lc_mem_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc_mem_model
// Description : Self-checking bench for lc_mem_model: directed scenarios plus
//               randomized traffic against a line-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc_mem_model;

    localparam int NUM_CH      = 2;
    localparam int LINE_BYTES  = 64;
    localparam int DEPTH_LINES = 64;
    localparam int LATENCY     = 4;
    localparam int LW          = LINE_BYTES * 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  load_valid = 1'b0;
    logic [63:0]           load_addr = '0;
    logic [LW-1:0]         load_value = '0;
    logic [NUM_CH-1:0]     req_valid = '0;
    logic [NUM_CH-1:0]     req_ready;
    logic [NUM_CH-1:0]     req_we = '0;
    logic [NUM_CH*64-1:0]  req_addr = '0;
    logic [NUM_CH*LW-1:0]  req_value = '0;
    logic [NUM_CH-1:0]     resp_valid;
    logic [NUM_CH-1:0]     resp_ready = '0;
    logic [63:0]           resp_addr;
    logic [LW-1:0]         resp_value;
    logic                  busy;
    logic                  err;

    int checks = 0;
    int errors = 0;

    logic [LW-1:0] mdl [DEPTH_LINES];

    always #5 clk = ~clk;

    lc_mem_model #(
        .NUM_CH(NUM_CH), .LINE_BYTES(LINE_BYTES),
        .DEPTH_LINES(DEPTH_LINES), .LATENCY(LATENCY)
    ) dut (
        .clk_in(clk), .rst_in(rst),
        .load_valid_in(load_valid), .load_addr_in(load_addr), .load_value_in(load_value),
        .req_valid_in(req_valid), .req_ready_out(req_ready), .req_we_in(req_we),
        .req_addr_in(req_addr), .req_value_in(req_value),
        .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
        .resp_addr_out(resp_addr), .resp_value_out(resp_value),
        .busy_out(busy), .err_out(err)
    );

    function automatic int lidx(input logic [63:0] a);
        return int'((a / LINE_BYTES) % DEPTH_LINES);
    endfunction

    function automatic logic [63:0] lalign(input logic [63:0] a);
        return (a / LINE_BYTES) * LINE_BYTES;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; resp_ready = '0; load_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preload_line(input logic [63:0] a, input logic [LW-1:0] v);
        @(negedge clk);
        load_valid = 1'b1; load_addr = a; load_value = v;
        @(negedge clk);
        load_valid = 1'b0;
        mdl[lidx(a)] = v;
    endtask

    task automatic set_req(input int ch, input logic we, input logic [63:0] a, input logic [LW-1:0] v);
        req_valid[ch] = 1'b1;
        req_we[ch] = we;
        req_addr[ch*64 +: 64] = a;
        req_value[ch*LW +: LW] = v;
    endtask

    // Waits for req_ready[ch], lets the accept edge pass, drops valid; ends at cycle T+1.
    task automatic wait_accept(input int ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (req_ready[ch]) ok = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        req_valid[ch] = 1'b0;
        #1;
    endtask

    // Returns the cycle offset from accept at which a response appears, -1 on timeout.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (lat <= 30 && resp_valid == '0) begin
            @(negedge clk); #1;
            lat++;
        end
        if (lat > 30) lat = -1;
    endtask

    task automatic finish_resp(input int ch);
        resp_ready[ch] = 1'b1;
        @(negedge clk);
        resp_ready = '0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '1;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_addr !== '0) begin errors++; $display("FAIL reset_resp_addr got %h want 0", resp_addr); end
        checks++; if (resp_value !== '0) begin errors++; $display("FAIL reset_resp_value got %h want 0", resp_value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_program_read();
        logic [LW-1:0] img;
        bit ok; int lat;
        for (int i = 0; i < DEPTH_LINES; i++) preload_line(64'(i * LINE_BYTES), rand_line());
        img = '0;
        img[31:0]  = 32'hD28000A0;
        img[63:32] = 32'hB1000400;
        img[95:64] = 32'hD4400000;
        preload_line(64'h0, img);
        @(negedge clk);
        set_req(0, 1'b0, 64'h0, '0);
        wait_accept(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prog_accept got none want ready[0]"); end
        wait_resp(lat);
        checks++; if (lat !== LATENCY) begin errors++; $display("FAIL prog_latency got %0d want %0d", lat, LATENCY); end
        checks++; if (resp_valid !== 2'b01 || resp_value !== img || resp_addr !== 64'h0) begin
            errors++; $display("FAIL prog_resp got v=%b a=%h d=%h want v=01 a=0 d=%h", resp_valid, resp_addr, resp_value, img);
        end
        finish_resp(0);
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL prog_resp_drop got %b want 0", resp_valid); end
    endtask

    task automatic test_round_robin();
        bit ok; int lat;
        do_reset();
        @(negedge clk);
        set_req(0, 1'b0, 64'h40, '0);
        set_req(1, 1'b0, 64'h80, '0);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_first_grant got %b want 01", req_ready); end
        wait_accept(0, ok);
        wait_resp(lat);
        checks++; if (lat !== LATENCY || resp_valid !== 2'b01 || resp_value !== mdl[1] || resp_addr !== 64'h40) begin
            errors++; $display("FAIL rr_ch0_resp got lat=%0d v=%b a=%h want lat=%0d v=01 a=40", lat, resp_valid, resp_addr, LATENCY);
        end
        finish_resp(0);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_second_grant got %b want 10", req_ready); end
        wait_accept(1, ok);
        wait_resp(lat);
        checks++; if (lat !== LATENCY || resp_valid !== 2'b10 || resp_value !== mdl[2] || resp_addr !== 64'h80) begin
            errors++; $display("FAIL rr_ch1_resp got lat=%0d v=%b a=%h want lat=%0d v=10 a=80", lat, resp_valid, resp_addr, LATENCY);
        end
        finish_resp(1);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_wrap got %b want 01", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_write_read();
        logic [LW-1:0] wd;
        bit ok; int lat;
        wd = {(LW/32){32'hDEADBEEF}};
        @(negedge clk);
        set_req(1, 1'b1, 64'h1C0, wd);
        wait_accept(1, ok);
        wait_resp(lat);
        checks++; if (!ok || resp_valid !== 2'b10 || resp_value !== wd || resp_addr !== 64'h1C0) begin
            errors++; $display("FAIL wr_echo got v=%b a=%h d=%h want v=10 a=1c0 d=%h", resp_valid, resp_addr, resp_value, wd);
        end
        mdl[7] = wd;
        finish_resp(1);
        set_req(0, 1'b0, 64'h1C4, '0);
        wait_accept(0, ok);
        wait_resp(lat);
        checks++; if (!ok || resp_valid !== 2'b01 || resp_value !== wd || resp_addr !== 64'h1C0) begin
            errors++; $display("FAIL rd_after_wr got v=%b a=%h d=%h want v=01 a=1c0 d=%h", resp_valid, resp_addr, resp_value, wd);
        end
        finish_resp(0);
    endtask

    task automatic test_stall();
        logic [LW-1:0] exp_v;
        logic [LW-1:0] nv;
        bit ok; int lat;
        exp_v = mdl[12];
        nv = rand_line();
        @(negedge clk);
        set_req(0, 1'b0, 64'h300, '0);
        wait_accept(0, ok);
        wait_resp(lat);
        set_req(1, 1'b0, 64'h0, '0);
        for (int i = 0; i < 10; i++) begin
            load_valid = (i == 3); load_addr = 64'h300; load_value = nv;
            #1;
            checks++; if (resp_valid !== 2'b01 || resp_value !== exp_v || resp_addr !== 64'h300 || busy !== 1'b1 || req_ready !== '0) begin
                errors++; $display("FAIL stall_hold[%0d] got v=%b a=%h busy=%b rdy=%b want v=01 a=300 busy=1 rdy=00", i, resp_valid, resp_addr, busy, req_ready);
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        mdl[12] = nv;
        req_valid = '0;
        #1;
        finish_resp(0);
    endtask

    task automatic test_out_of_range();
        logic [LW-1:0] exp_v;
        logic exp_e;
        bit ok; int lat;
`ifdef LC_MEM_ERR_EN
        exp_v = '0; exp_e = 1'b1;
`else
        exp_v = mdl[0]; exp_e = 1'b0;
`endif
        @(negedge clk);
        set_req(0, 1'b0, 64'h1000, '0);
        wait_accept(0, ok);
        wait_resp(lat);
        checks++; if (!ok || resp_valid !== 2'b01 || resp_value !== exp_v || resp_addr !== 64'h1000 || err !== exp_e) begin
            errors++; $display("FAIL oor_read got v=%b a=%h e=%b want v=01 a=1000 e=%b", resp_valid, resp_addr, err, exp_e);
        end
        finish_resp(0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_err_drop got %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] wd;
        bit ok; int lat; bit seen;
        wd = rand_line();
        @(negedge clk);
        set_req(0, 1'b1, 64'h240, wd);
        wait_accept(0, ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== '0) begin
            errors++; $display("FAIL mid_reset got busy=%b v=%b want busy=0 v=00", busy, resp_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (resp_valid != '0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL mid_reset_noresp got response want none"); end
        mdl[9] = wd;
        set_req(0, 1'b0, 64'h240, '0);
        wait_accept(0, ok);
        wait_resp(lat);
        checks++; if (!ok || lat !== LATENCY || resp_value !== wd || resp_addr !== 64'h240) begin
            errors++; $display("FAIL post_reset_read got lat=%0d a=%h want lat=%0d a=240 committed data", lat, resp_addr, LATENCY);
        end
        finish_resp(0);
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] pv;
        logic [NUM_CH-1:0] pwe;
        logic [63:0]       pa [NUM_CH];
        logic [LW-1:0]     pd [NUM_CH];
        logic [NUM_CH-1:0] exp_ready;
        logic [NUM_CH-1:0] exp_valid;
        logic [LW-1:0]     ov;
        logic [63:0]       oa;
        int rr, och, age, g;
        bit outst;
        do_reset();
        pv = '0; pwe = '0; rr = 0; och = 0; age = 0; outst = 1'b0; ov = '0; oa = '0;
        for (int c = 0; c < NUM_CH; c++) begin pa[c] = '0; pd[c] = '0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (outst) age++;
            for (int c = 0; c < NUM_CH; c++) begin
                if (!pv[c] && cyc < 560 && $urandom_range(0, 99) < 40) begin
                    pv[c] = 1'b1;
                    pwe[c] = ($urandom_range(0, 2) == 0);
                    pa[c] = 64'($urandom_range(0, DEPTH_LINES * LINE_BYTES - 1));
                    pd[c] = rand_line();
                end
                req_valid[c] = pv[c];
                req_we[c] = pwe[c];
                req_addr[c*64 +: 64] = pa[c];
                req_value[c*LW +: LW] = pd[c];
            end
            load_valid = ($urandom_range(0, 9) == 0);
            load_addr = 64'($urandom_range(0, DEPTH_LINES * LINE_BYTES - 1));
            load_value = rand_line();
            resp_ready = NUM_CH'($urandom);
            #1;
            g = -1;
            if (!outst && !load_valid) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (g < 0 && pv[(rr + k) % NUM_CH]) g = (rr + k) % NUM_CH;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_valid = '0;
            if (outst && age >= LATENCY) exp_valid[och] = 1'b1;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", cyc, req_ready, exp_ready); end
            checks++; if (resp_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", cyc, resp_valid, exp_valid); end
            if (outst && age >= LATENCY) begin
                checks++; if (resp_value !== ov || resp_addr !== oa || err !== 1'b0) begin
                    errors++; $display("FAIL rnd_data[%0d] got a=%h e=%b want a=%h e=0", cyc, resp_addr, err, oa);
                end
                if (resp_ready[och]) outst = 1'b0;
            end
            if (g >= 0) begin
                ov = pwe[g] ? pd[g] : mdl[lidx(pa[g])];
                if (pwe[g]) mdl[lidx(pa[g])] = pd[g];
                oa = lalign(pa[g]);
                outst = 1'b1; age = 0; och = g;
                rr = (g + 1) % NUM_CH;
                pv[g] = 1'b0;
            end
            if (load_valid) mdl[lidx(load_addr)] = load_value;
        end
        @(negedge clk);
        req_valid = '0; load_valid = 1'b0; resp_ready = '0;
    endtask

    initial begin
        test_reset();
        test_program_read();
        test_round_robin();
        test_write_read();
        test_stall();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lc_mem_model.md
# lc_mem_model

Parametrised last-level-cache (LC) responder that serves line-sized read and write requests from `NUM_CH` L1 clients (L1I, L1D, …) over valid/ready handshakes, with a configurable access latency. It replaces single-shot, bench-driven LC stimulus with a reactive backing store. A backdoor preload port lets benches place program images in memory. It sits between the `ozone` L1 caches' LC ports and the testbench, and is also usable as an FPGA block-RAM stand-in.

## Interface
Parameters:
- `NUM_CH`, 2: number of L1 client channels (≥1).
- `LINE_BYTES`, 64: cache line size in bytes (power of two).
- `DEPTH_LINES`, 64: memory depth in lines (power of two); 64×64 B = 4 KB.
- `LATENCY`, 4: cycles from request accept to response valid (≥1).

Ports (clock and reset first). Per-channel buses are flattened, with channel i at slice i:
- `clk_in`  in  1  clock; all logic is rising-edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `load_valid_in`  in  1  backdoor line write.
- `load_addr_in`  in  64  backdoor byte address.
- `load_value_in`  in  LINE_BYTES*8  backdoor line data.
- `req_valid_in`  in  NUM_CH  request valid, per channel.
- `req_ready_out`  out  NUM_CH  request accepted this cycle when valid&ready.
- `req_we_in`  in  NUM_CH  1 = write, 0 = read.
- `req_addr_in`  in  NUM_CH*64  request byte address.
- `req_value_in`  in  NUM_CH*LINE_BYTES*8  write data.
- `resp_valid_out`  out  NUM_CH  response valid, one-hot or zero.
- `resp_ready_in`  in  NUM_CH  client can take the response.
- `resp_addr_out`  out  64  line-aligned address of the response.
- `resp_value_out`  out  LINE_BYTES*8  read data, or echoed write data.
- `busy_out`  out  1  high when the FSM is not IDLE.
- `err_out`  out  1  out-of-range flag; present only with `LC_MEM_ERR_EN`, otherwise tied 0.

## Operation
- Line index = `addr[OFF_W +: IDX_W]`, where OFF_W = log2(LINE_BYTES) and IDX_W = log2(DEPTH_LINES). Offset bits are ignored and responses return the line-aligned address.
- FSM states:
  - IDLE: on the cycle a request is accepted, go to WAIT.
  - WAIT: count down LATENCY−1 cycles, then go to RESP.
  - RESP: hold the response; when `resp_ready_in[ch]` is high, go to IDLE.
  - LATENCY=1 skips WAIT entirely (IDLE→RESP).
- Arbitration is round-robin:
  - Grant goes to the lowest channel index ≥ `rr_ptr` with valid set, wrapping to 0.
  - `req_ready_out[g]` = (state==IDLE) && !`load_valid_in` && granted. It is combinational, and at most one bit is high.
  - On accept, `rr_ptr` ← (g+1) mod NUM_CH.
- Read: the line is captured into the response register on the accept cycle.
- Write: the line is written on the accept cycle, and the response echoes the written data as an acknowledgement.
- Preload:
  - A write happens every cycle `load_valid_in` is high, in any state.
  - It blocks new accepts but does not disturb an in-flight transaction, whose data was already captured.
- Memory contents are not affected by reset.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE, `rr_ptr`=0, latency counter is 0.
- Accept on cycle T → `resp_valid_out[g]` rises at T+LATENCY.
- The response stays stable while `resp_ready_in[g]` is low.
- The response handshake completes on the cycle valid&ready are both high; `resp_valid_out` is 0 the next cycle.
- The earliest next accept is the cycle after the handshake, so back-to-back throughput is one request per LATENCY+1 cycles.
- Simultaneous valid on all channels: served in round-robin order with no starvation. The maximum wait is NUM_CH−1 transactions.
- Reset asserted mid-WAIT or mid-RESP aborts the transaction with no response. A write that was already accepted stays committed.
- Same-line read following a write returns the new data.

## Configuration
- `LC_MEM_ERR_EN` defined:
  - Any request whose address bits above OFF_W+IDX_W are nonzero is out of range.
  - An out-of-range write is dropped.
  - An out-of-range read returns zero data.
  - `err_out` is high alongside `resp_valid_out` for that response only.
  - An out-of-range preload is ignored.
- Not defined: upper address bits are ignored, addresses wrap modulo memory size, and `err_out` is constant 0.

## Test plan
- Preload line 0 with a MOVZ/ADDS/HLT image, ch0 reads 0x0 at T → resp_valid[0] at T+4, value equals the image, resp_addr=0x0.
- ch0 and ch1 both hold valid reads (0x40, 0x80) from reset → ch0 is served first, then ch1. rr_ptr returns to 0, and each response carries the correct line.
- ch1 writes 0xDEAD… to 0x1C0, then ch0 reads 0x1C4 → the write echo is returned, then the read returns 0xDEAD…, and resp_addr=0x1C0.
- Hold resp_ready_in low for 10 cycles → resp_valid, value and addr stay stable, busy_out=1, and all req_ready_out=0.
- Read 0x1000 (DEPTH 64) → returns line 0 without `LC_MEM_ERR_EN`; with it, returns zeros and err_out=1.
- Assert rst_in two cycles after accept → no resp_valid, busy_out=0 next cycle, and the following request completes normally.
